// File: rtl/demultiplexer_1to3_reg.sv
// Registered 1-to-3 demultiplexer with a one-word pipeline register,
// valid/ready backpressure and a per-output delivered-word counter.
//
// state | meaning
// ------+-------------------------------------------------------------
// EMPTY | no word held; In_Ready=1, all Out_ValidN=0
// FULL  | word held in Data_Q for output Dest_Q; waits for that sink
module demultiplexer_1to3_reg #(
  parameter int NBits     = 32,
  parameter int CountBits = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           Selector,
  input  logic [NBits-1:0]     DEMUX_Data,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  output logic [NBits-1:0]     Out_Data,
  output logic                 Out_Valid0,
  output logic                 Out_Valid1,
  output logic                 Out_Valid2,
  input  logic                 Out_Ready0,
  input  logic                 Out_Ready1,
  input  logic                 Out_Ready2,
  input  logic                 Clear,
  output logic [CountBits-1:0] Count0,
  output logic [CountBits-1:0] Count1,
  output logic [CountBits-1:0] Count2
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NBits-1:0]     data_q, data_d;
  logic [1:0]           dest_q, dest_d;
  logic [CountBits-1:0] count0_q, count0_d;
  logic [CountBits-1:0] count1_q, count1_d;
  logic [CountBits-1:0] count2_q, count2_d;

  logic       ready_sel;
  logic       drain;
  logic       accept;
  logic [1:0] dest_map;

  // Selector code 11 folds onto output 0 so Dest_Q only ever holds 0..2.
  always_comb begin
    dest_map = 2'd0;
    case (Selector)
      2'b01:   dest_map = 2'd1;
      2'b10:   dest_map = 2'd2;
      default: dest_map = 2'd0;
    endcase
  end

  // Only the ready of the held word's destination matters; In_Ready is
  // combinational from it so a draining register can refill in the same cycle.
  always_comb begin
    ready_sel = 1'b0;
    case (dest_q)
      2'd1:    ready_sel = Out_Ready1;
      2'd2:    ready_sel = Out_Ready2;
      default: ready_sel = Out_Ready0;
    endcase
    drain    = (state_q == FULL) && ready_sel;
    In_Ready = (state_q == EMPTY) || drain;
    accept   = In_Valid && In_Ready;
  end

  // Next-state: accept loads a new word, a lone drain empties, otherwise hold.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dest_d  = dest_q;
    if (accept) begin
      state_d = FULL;
      data_d  = DEMUX_Data;
      dest_d  = dest_map;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  // Counter next-state: clear wins over a coincident increment; wrap is silent.
  always_comb begin
    count0_d = count0_q;
    count1_d = count1_q;
    count2_d = count2_q;
    if (Clear) begin
      count0_d = '0;
      count1_d = '0;
      count2_d = '0;
    end else if (drain) begin
      case (dest_q)
        2'd1:    count1_d = count1_q + 1'b1;
        2'd2:    count2_d = count2_q + 1'b1;
        default: count0_d = count0_q + 1'b1;
      endcase
    end
  end

  // Pipeline register and counters; reset discards any in-flight word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      data_q   <= '0;
      dest_q   <= 2'd0;
      count0_q <= '0;
      count1_q <= '0;
      count2_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      dest_q   <= dest_d;
      count0_q <= count0_d;
      count1_q <= count1_d;
      count2_q <= count2_d;
    end
  end

  // Outputs: shared data bus, one-hot valid for the held destination.
  always_comb begin
    Out_Data   = data_q;
    Out_Valid0 = (state_q == FULL) && (dest_q == 2'd0);
    Out_Valid1 = (state_q == FULL) && (dest_q == 2'd1);
    Out_Valid2 = (state_q == FULL) && (dest_q == 2'd2);
    Count0     = count0_q;
    Count1     = count1_q;
    Count2     = count2_q;
  end

endmodule

// File: tb/tb_demultiplexer_1to3_reg.sv
// Directed bench for demultiplexer_1to3_reg, built with 4-bit counters so
// that counter wrap can be reached quickly.
module tb_demultiplexer_1to3_reg;

  localparam int NB = 32;
  localparam int CB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    Selector;
  logic [NB-1:0] DEMUX_Data;
  logic          In_Valid;
  logic          In_Ready;
  logic [NB-1:0] Out_Data;
  logic          Out_Valid0, Out_Valid1, Out_Valid2;
  logic          Out_Ready0, Out_Ready1, Out_Ready2;
  logic          Clear;
  logic [CB-1:0] Count0, Count1, Count2;

  int errors = 0;
  int checks = 0;

  demultiplexer_1to3_reg #(.NBits(NB), .CountBits(CB)) dut (
    .clk        (clk),
    .reset      (reset),
    .Selector   (Selector),
    .DEMUX_Data (DEMUX_Data),
    .In_Valid   (In_Valid),
    .In_Ready   (In_Ready),
    .Out_Data   (Out_Data),
    .Out_Valid0 (Out_Valid0),
    .Out_Valid1 (Out_Valid1),
    .Out_Valid2 (Out_Valid2),
    .Out_Ready0 (Out_Ready0),
    .Out_Ready1 (Out_Ready1),
    .Out_Ready2 (Out_Ready2),
    .Clear      (Clear),
    .Count0     (Count0),
    .Count1     (Count1),
    .Count2     (Count2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_valids(input string tag, input logic [2:0] exp);
    check(tag, {61'd0, Out_Valid2, Out_Valid1, Out_Valid0}, {61'd0, exp});
  endtask

  task automatic send(input logic [1:0] sel, input logic [NB-1:0] d);
    Selector   = sel;
    DEMUX_Data = d;
    In_Valid   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; Selector = 2'b00; DEMUX_Data = '0; In_Valid = 1'b0;
    Out_Ready0 = 1'b1; Out_Ready1 = 1'b1; Out_Ready2 = 1'b1; Clear = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("idle_in_ready", In_Ready, 1);
    check_valids("idle_valid", 3'b000);
    check("idle_data", Out_Data, 0);
    check("idle_counts", {Count2, Count1, Count0}, 0);

    // Routing: 01 -> out1, 10 -> out2, 11 -> out0
    send(2'b01, 32'hA0000001); tick();
    check_valids("rt1_valid", 3'b010);
    check("rt1_data", Out_Data, 32'hA0000001);
    send(2'b10, 32'hB0000002); tick();
    check_valids("rt2_valid", 3'b100);
    check("rt2_data", Out_Data, 32'hB0000002);
    check("rt2_count1", Count1, 1);
    send(2'b11, 32'hC0000003); tick();
    check_valids("rt3_valid", 3'b001);
    check("rt3_data", Out_Data, 32'hC0000003);
    check("rt3_count2", Count2, 1);
    In_Valid = 1'b0; tick();
    check_valids("rt_done_valid", 3'b000);
    check("rt_counts", {Count2, Count1, Count0}, {4'd1, 4'd1, 4'd1});

    Clear = 1'b1; tick(); Clear = 1'b0;
    check("clear_idle", {Count2, Count1, Count0}, 0);

    // Backpressure on output 2
    Out_Ready2 = 1'b0;
    send(2'b10, 32'h12345678); tick();
    send(2'b01, 32'hFFFFFFFF);
    for (int i = 0; i < 5; i++) begin
      check_valids("bp_valid", 3'b100);
      check("bp_data", Out_Data, 32'h12345678);
      check("bp_in_ready", In_Ready, 0);
      tick();
    end
    In_Valid = 1'b0; Out_Ready2 = 1'b1;
    #1;
    check("bp_drain_ready", In_Ready, 1);
    tick();
    check_valids("bp_after_valid", 3'b000);
    check("bp_count2", Count2, 1);

    // Non-selected ready ignored
    Out_Ready1 = 1'b0;
    send(2'b01, 32'hDEADBEEF); tick();
    In_Valid = 1'b0;
    check("ns_in_ready", In_Ready, 0);
    tick();
    check_valids("ns_hold_valid", 3'b010);
    check("ns_hold_data", Out_Data, 32'hDEADBEEF);
    check("ns_counts", {Count2, Count1, Count0}, {4'd1, 4'd0, 4'd0});
    Out_Ready1 = 1'b1; tick();
    check_valids("ns_drained", 3'b000);
    check("ns_count1", Count1, 1);

    // Streaming to output 0
    Clear = 1'b1; tick(); Clear = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(2'b00, 32'h100 + i);
      #1;
      check("st_in_ready", In_Ready, 1);
      tick();
      check_valids("st_valid", 3'b001);
      check("st_data", Out_Data, 32'h100 + i);
    end
    In_Valid = 1'b0; tick();
    check("st_count0", Count0, 8);
    send(2'b00, 32'h55AA55AA); tick();
    In_Valid = 1'b0; Clear = 1'b1; tick(); Clear = 1'b0;
    check("st_clear_on_drain", Count0, 0);
    check_valids("st_clear_valid", 3'b000);

    // Counter wrap on output 1 with 4-bit counters
    Clear = 1'b1; tick(); Clear = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send(2'b01, 32'h200 + i);
      tick();
    end
    check("wrap_at_16", Count1, 0);
    In_Valid = 1'b0; tick();
    check("wrap_count1", Count1, 1);

    // Asynchronous reset between edges while FULL
    Out_Ready2 = 1'b0;
    send(2'b10, 32'h0BADF00D); tick();
    In_Valid = 1'b0;
    check_valids("ar_full", 3'b100);
    #2 reset = 1'b0;
    #1;
    check_valids("ar_valid", 3'b000);
    check("ar_data", Out_Data, 0);
    check("ar_counts", {Count2, Count1, Count0}, 0);
    check("ar_in_ready", In_Ready, 1);
    tick();
    reset = 1'b1;
    tick();
    check_valids("ar_after_release", 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demultiplexer_1to3_reg.md
# demultiplexer_1to3_reg

Registered 1-to-3 demultiplexer. It routes each word from a single valid/ready source to one of three valid/ready sinks, chosen by a 2-bit selector, and is the routing counterpart of the 3-to-1 multiplexer. It holds a one-word pipeline register with backpressure and keeps a per-output transfer counter. It sits in the datapath wherever one producer must steer results to one of three consumers.

## Interface
- NBits, 32, data width
- CountBits, 16, width of each per-output transfer counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- Selector  in  2  destination for the incoming word: 00→0, 01→1, 10→2, 11→0
- DEMUX_Data  in  NBits  incoming word
- In_Valid  in  1  source presents a word
- In_Ready  out  1  block accepts a word this cycle
- Out_Data  out  NBits  registered word, shared by all three outputs
- Out_Valid0/1/2  out  1 each  word held for output N
- Out_Ready0/1/2  in  1 each  sink N accepts
- Clear  in  1  synchronous clear of the transfer counters
- Count0/1/2  out  CountBits each  words delivered to output N

## Operation
- State: Data_Q[NBits-1:0], Dest_Q[1:0] (values 0..2 only), Full_Q. The two states are EMPTY (Full_Q=0) and FULL (Full_Q=1).
- Out_Data = Data_Q. Out_ValidN = Full_Q & (Dest_Q==N).
- Drain = Full_Q & Out_Ready[Dest_Q]. The ready inputs of non-selected outputs are ignored.
- In_Ready = ~Full_Q | Drain. This is combinational from Out_Ready, so a FULL register that drains in the same cycle still accepts a new word.
- Accept = In_Valid & In_Ready. On Accept: Data_Q←DEMUX_Data, Dest_Q←map(Selector), Full_Q←1. This applies in both EMPTY and FULL+Drain.
- Drain without Accept: Full_Q←0. Data_Q and Dest_Q keep their values.
- FULL without Drain: all registers hold. Out_Data and Out_ValidN must stay stable until the sink accepts.
- Selector, DEMUX_Data and In_Valid are ignored when In_Ready=0. Selector is sampled only on Accept, so changing it while FULL does not reroute the held word.
- Counters:
  - CountN increments by 1 on each cycle with Drain and Dest_Q==N.
  - Counters wrap from 2^CountBits−1 to 0 with no flag.
  - Clear=1 sets all three counters to 0, and overrides a coincident increment (result 0).
  - Clear has no effect on the datapath.

## Timing
- Reset asserted (asynchronous, any time, including mid-transfer): Full_Q=0, Data_Q=0, Dest_Q=0, Count0..2=0, Out_Valid0..2=0, Out_Data=0, In_Ready=1. An in-flight word is discarded.
- Latency is 1 cycle: a word accepted at edge k appears on Out_Data/Out_ValidN after edge k.
- Throughput is 1 word per cycle while the destination sink holds Out_Ready high.
- Simultaneous Drain and Accept: the new word replaces the old at the edge, Full_Q stays 1, and the counter for the old destination increments.
- Back-to-back words to different outputs: Out_Valid moves from one output to the other on consecutive cycles with no bubble.
- A count is visible on CountN the cycle after the Drain edge.

## Test plan
- Reset/idle: hold reset=0 then release with In_Valid=0 → In_Ready=1, all Out_Valid=0, Out_Data=0, Count0..2=0.
- Routing: send 0xA0000001 with Selector=01, then 0xB0000002 with 10, then 0xC0000003 with 11, all sinks ready → each appears one cycle later on outputs 1, 2 and 0 respectively; Count0=1, Count1=1, Count2=1.
- Backpressure: send 0x12345678 with Selector=10, Out_Ready2=0 for 5 cycles → Out_Valid2=1 with data stable, In_Ready=0, Selector/data changes ignored. Raise Out_Ready2 → one transfer, Count2=1.
- Non-selected ready ignored: word held for output 1 with Out_Ready1=0, Out_Ready0=Out_Ready2=1 → no drain, In_Ready=0.
- Streaming: 8 consecutive words with Selector=00, Out_Ready0=1 → In_Ready stays 1, 8 outputs with 1-cycle latency, Count0=8. Then assert Clear on a drain cycle → Count0=0.
- Wrap and async reset: CountBits=4, deliver 17 words to output 1 → Count1=1. Assert reset mid-FULL between clock edges → Out_Valid drops immediately, counters 0.
